// File: rtl/lsu_dbus_pkg.sv
// rtl/lsu_dbus_pkg.sv - shared mem_type codes, LSU state encoding and alignment helper
package lsu_dbus_pkg;

    localparam int MEM_TYPE_W = 2;

    // mem_type codes; 2'b11 is decoded as a word access everywhere
    localparam logic [MEM_TYPE_W-1:0] LS_B = 2'b00;
    localparam logic [MEM_TYPE_W-1:0] LS_H = 2'b01;
    localparam logic [MEM_TYPE_W-1:0] LS_W = 2'b10;

    // mem_sign value selecting zero-extension
    localparam logic LS_UNSIGNED = 1'b1;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_WAIT = 2'b10,
        LSU_DONE = 2'b11
    } lsu_state_e;

    // True when the low address bits violate the natural alignment of the access
    function automatic logic is_misaligned(input logic [MEM_TYPE_W-1:0] t,
                                           input logic [1:0] lo);
        logic m;
        m = 1'b0;
        case (t)
            LS_B:    m = 1'b0;
            LS_H:    m = lo[0];
            default: m = |lo;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_dbus_align.sv
// rtl/lsu_dbus_align.sv - combinational byte-lane generation and load extract/extend
//
// Ports:
//   st_type, st_lo, st_data  -> st_be, st_lanes : store byte enables and lane-replicated data
//   ld_type, ld_lo, ld_sign, bus_rdata -> ld_data : lane-selected, sign/zero-extended load
// Misaligned low bits are forced to natural alignment: half uses only lo[1], word ignores lo.
module lsu_dbus_align
    import lsu_dbus_pkg::*;
(
    input  logic [1:0]  st_type,
    input  logic [1:0]  st_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_lanes,
    input  logic [1:0]  ld_type,
    input  logic [1:0]  ld_lo,
    input  logic        ld_sign,
    input  logic [31:0] bus_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be    = 4'b1111;
        st_lanes = st_data;
        case (st_type)
            LS_B: begin
                st_be    = 4'b0001 << st_lo;
                st_lanes = {4{st_data[7:0]}};
            end
            LS_H: begin
                st_be    = 4'b0011 << {st_lo[1], 1'b0};
                st_lanes = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = bus_rdata[{ld_lo, 3'b000} +: 8];
        ld_half = ld_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        ld_data = bus_rdata;
        case (ld_type)
            LS_B: ld_data = (ld_sign == LS_UNSIGNED) ? {24'h0, ld_byte}
                                                     : {{24{ld_byte[7]}}, ld_byte};
            LS_H: ld_data = (ld_sign == LS_UNSIGNED) ? {16'h0, ld_half}
                                                     : {{16{ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_dbus.sv
// rtl/lsu_dbus.sv - load/store unit driving a req/gnt/rvalid data bus
//
// Core side : rdmem, wmem, mem_type, mem_sign, addr, wdata in; rdata, done, hold, bus_err out.
// Bus side  : dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata out; dbus_gnt, dbus_rvalid,
//             dbus_rdata in.
// Optional  : LSU_MISALIGN_TRAP_EN - misaligned half/word accesses skip the bus and finish
//             with bus_err; otherwise the low address bits are forced to natural alignment.
module lsu_dbus
    import lsu_dbus_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          rdmem,
    input  logic          wmem,
    input  logic [1:0]    mem_type,
    input  logic          mem_sign,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          done,
    output logic          hold,
    output logic          bus_err,
    output logic          dbus_req,
    output logic          dbus_we,
    output logic [AW-1:0] dbus_addr,
    output logic [3:0]    dbus_be,
    output logic [DW-1:0] dbus_wdata,
    input  logic          dbus_gnt,
    input  logic          dbus_rvalid,
    input  logic [DW-1:0] dbus_rdata
);

    localparam int CW = $clog2(TIMEOUT);

    lsu_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    type_q, type_d;
    logic [1:0]    lo_q, lo_d;
    logic          sign_q, sign_d;
    logic          we_q, we_d;
    logic [AW-1:0] baddr_q, baddr_d;
    logic [3:0]    be_q, be_d;
    logic [DW-1:0] bwdata_q, bwdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [3:0]    st_be;
    logic [DW-1:0] st_lanes;
    logic [DW-1:0] ld_data;
    logic          timed_out;

    lsu_dbus_align u_align (
        .st_type   (mem_type),
        .st_lo     (addr[1:0]),
        .st_data   (wdata),
        .st_be     (st_be),
        .st_lanes  (st_lanes),
        .ld_type   (type_q),
        .ld_lo     (lo_q),
        .ld_sign   (sign_q),
        .bus_rdata (dbus_rdata),
        .ld_data   (ld_data)
    );

    assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        type_d   = type_q;
        lo_d     = lo_q;
        sign_d   = sign_q;
        we_d     = we_q;
        baddr_d  = baddr_q;
        be_d     = be_q;
        bwdata_d = bwdata_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (rdmem || wmem) begin
                    type_d   = mem_type;
                    lo_d     = addr[1:0];
                    sign_d   = mem_sign;
                    we_d     = wmem & ~rdmem;   // simultaneous rd/wr resolves to a load
                    baddr_d  = {addr[AW-1:2], 2'b00};
                    be_d     = st_be;
                    bwdata_d = st_lanes;
                    cnt_d    = '0;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (is_misaligned(mem_type, addr[1:0])) begin
                        state_d = LSU_DONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = LSU_REQ;
                    end
`else
                    state_d = LSU_REQ;
`endif
                end
            end
            LSU_REQ: begin
                if (dbus_gnt && dbus_rvalid) begin
                    state_d = LSU_DONE;
                    cnt_d   = '0;
                    if (!we_q) rdata_d = ld_data;
                end else if (dbus_gnt) begin
                    state_d = LSU_WAIT;
                    cnt_d   = '0;
                end else if (timed_out) begin
                    state_d = LSU_DONE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LSU_WAIT: begin
                if (dbus_rvalid) begin
                    state_d = LSU_DONE;
                    cnt_d   = '0;
                    if (!we_q) rdata_d = ld_data;
                end else if (timed_out) begin
                    state_d = LSU_DONE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                // DONE: request inputs are ignored for this cycle
                state_d = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= LSU_IDLE;
            cnt_q    <= '0;
            type_q   <= '0;
            lo_q     <= '0;
            sign_q   <= 1'b0;
            we_q     <= 1'b0;
            baddr_q  <= '0;
            be_q     <= '0;
            bwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            type_q   <= type_d;
            lo_q     <= lo_d;
            sign_q   <= sign_d;
            we_q     <= we_d;
            baddr_q  <= baddr_d;
            be_q     <= be_d;
            bwdata_q <= bwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign dbus_req   = (state_q == LSU_REQ);
    assign done       = (state_q == LSU_DONE);
    assign bus_err    = err_q;
    assign dbus_we    = we_q;
    assign dbus_addr  = baddr_q;
    assign dbus_be    = be_q;
    assign dbus_wdata = bwdata_q;
    assign rdata      = rdata_q;
    // hold is combinational on the request so control stalls in the accept cycle;
    // gated by rstn so every output reads 0 while reset is applied
    assign hold = rstn & (((state_q == LSU_IDLE) & (rdmem | wmem)) |
                          (state_q == LSU_REQ) | (state_q == LSU_WAIT));

endmodule

// File: tb/tb_lsu_dbus.sv
// tb/tb_lsu_dbus.sv - directed self-checking bench for lsu_dbus
module tb_lsu_dbus;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rdmem, wmem, mem_sign;
    logic [1:0]  mem_type;
    logic [31:0] addr, wdata, rdata;
    logic        done, hold, bus_err;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;
    logic        dbus_gnt, dbus_rvalid;

    int checks = 0;
    int errors = 0;

    int   hcnt, rcnt;
    logic seen_done, seen_err;

    always #5 clk = ~clk;

    lsu_dbus #(.AW(32), .DW(32), .TIMEOUT(64)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .rdmem       (rdmem),
        .wmem        (wmem),
        .mem_type    (mem_type),
        .mem_sign    (mem_sign),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .done        (done),
        .hold        (hold),
        .bus_err     (bus_err),
        .dbus_req    (dbus_req),
        .dbus_we     (dbus_we),
        .dbus_addr   (dbus_addr),
        .dbus_be     (dbus_be),
        .dbus_wdata  (dbus_wdata),
        .dbus_gnt    (dbus_gnt),
        .dbus_rvalid (dbus_rvalid),
        .dbus_rdata  (dbus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_ctl"}, {28'h0, done, hold, bus_err, dbus_req}, 32'h0);
        chk({tag, "_we"}, {31'h0, dbus_we}, 32'h0);
        chk({tag, "_addr"}, dbus_addr, 32'h0);
        chk({tag, "_be"}, {28'h0, dbus_be}, 32'h0);
        chk({tag, "_wdata"}, dbus_wdata, 32'h0);
    endtask

    // Starts in IDLE at posedge+2; returns in the DONE cycle with request inputs dropped.
    // The bus model grants on REQ cycle number gdly and returns rvalid rdly cycles after.
    task automatic xact(input logic rd, input logic wr, input logic [1:0] t, input logic s,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] brd,
                        input int gdly, input int rdly);
        int   since_g;
        logic granted;
        rdmem = rd; wmem = wr; mem_type = t; mem_sign = s; addr = a; wdata = wd;
        dbus_rdata = brd;
        hcnt = 0; rcnt = 0; seen_done = 1'b0; seen_err = 1'b0;
        granted = 1'b0; since_g = 0;
        for (int c = 0; c < 300 && !seen_done; c++) begin
            dbus_gnt    = dbus_req && (rcnt == gdly);
            dbus_rvalid = (dbus_gnt && rdly == 0) || (granted && since_g == rdly);
            #1;
            if (hold) hcnt++;
            if (dbus_req) rcnt++;
            if (granted) since_g++;
            if (dbus_gnt) begin granted = 1'b1; since_g = 1; end
            if (done) begin
                seen_done = 1'b1;
                seen_err  = bus_err;
                rdmem = 1'b0; wmem = 1'b0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
                #1;
            end else begin
                tick();
            end
        end
        chk("xact_done_seen", {31'h0, seen_done}, 32'h1);
    endtask

    initial begin
        rstn = 1'b0; rdmem = 1'b0; wmem = 1'b0; mem_type = 2'b00; mem_sign = 1'b0;
        addr = '0; wdata = '0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
        tick(); tick();
        chk_all_zero("reset");
        rstn = 1'b1;
        tick();

        // signed byte load, gnt+rvalid in the first REQ cycle
        xact(1'b1, 1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 32'h80FF_FFFF, 0, 0);
        chk("sb_rdata", rdata, 32'hFFFF_FF80);
        chk("sb_be", {28'h0, dbus_be}, 32'h8);
        chk("sb_hold_cycles", hcnt, 2);
        chk("sb_done_hold", {30'h0, done, hold}, 32'h2);
        chk("sb_err", {31'h0, seen_err}, 32'h0);
        tick();
        chk("sb_done_pulse", {31'h0, done}, 32'h0);

        // byte store with write ack one cycle after gnt
        xact(1'b0, 1'b1, 2'b00, 1'b0, 32'h3001, 32'h0000_00A5, 32'hDEAD_BEEF, 0, 1);
        chk("sw_we", {31'h0, dbus_we}, 32'h1);
        chk("sw_be", {28'h0, dbus_be}, 32'h2);
        chk("sw_wdata", dbus_wdata, 32'hA5A5_A5A5);
        chk("sw_addr", dbus_addr, 32'h3000);
        chk("sw_rdata_kept", rdata, 32'hFFFF_FF80);
        chk("sw_hold_cycles", hcnt, 3);
        tick();

        // unsigned half load, gnt after 3 stalled REQ cycles, rvalid 2 cycles later
        xact(1'b1, 1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 32'hBEEF_1234, 3, 2);
        chk("uh_rdata", rdata, 32'h0000_BEEF);
        chk("uh_be", {28'h0, dbus_be}, 32'hC);
        chk("uh_hold_cycles", hcnt, 7);
        chk("uh_req_cycles", rcnt, 4);
        tick();

        // rdmem and wmem together resolve to a signed half load
        xact(1'b1, 1'b1, 2'b01, 1'b0, 32'h5000, 32'hFFFF_FFFF, 32'h1234_8001, 1, 0);
        chk("both_we", {31'h0, dbus_we}, 32'h0);
        chk("both_rdata", rdata, 32'hFFFF_8001);
        chk("both_be", {28'h0, dbus_be}, 32'h3);
        tick();

        // reset while WAIT is outstanding
        rdmem = 1'b1; mem_type = 2'b10; addr = 32'h6004; dbus_rdata = 32'h7777_7777;
        tick();
        chk("rst_req_issued", {31'h0, dbus_req}, 32'h1);
        dbus_gnt = 1'b1;
        tick();
        dbus_gnt = 1'b0;
        chk("rst_in_wait", {30'h0, dbus_req, hold}, 32'h1);
        rstn = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        rdmem = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        dbus_rvalid = 1'b1;
        tick();
        chk("rst_stale_rvalid_done", {30'h0, done, hold}, 32'h0);
        dbus_rvalid = 1'b0;
        tick();
        chk("rst_stale_rvalid_done2", {31'h0, done}, 32'h0);

        // misaligned word load
        xact(1'b1, 1'b0, 2'b10, 1'b0, 32'h4002, 32'h0, 32'h1122_3344, 1, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_req_cycles", rcnt, 0);
        chk("mis_err", {31'h0, seen_err}, 32'h1);
        chk("mis_rdata", rdata, 32'h0);
        chk("mis_hold_cycles", hcnt, 1);
`else
        chk("mis_addr", dbus_addr, 32'h4000);
        chk("mis_be", {28'h0, dbus_be}, 32'hF);
        chk("mis_rdata", rdata, 32'h1122_3344);
        chk("mis_hold_cycles", hcnt, 4);
        chk("mis_err", {31'h0, seen_err}, 32'h0);
`endif
        tick();

        // timeout with gnt never asserted
        xact(1'b1, 1'b0, 2'b10, 1'b0, 32'h7000, 32'h0, 32'hCAFE_F00D, 100000, 0);
        chk("to_req_cycles", rcnt, 64);
        chk("to_hold_cycles", hcnt, 65);
        chk("to_err", {31'h0, seen_err}, 32'h1);
        chk("to_rdata", rdata, 32'h0);
        chk("to_req_low", {31'h0, dbus_req}, 32'h0);
        tick();
        chk("to_idle", {28'h0, done, hold, bus_err, dbus_req}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
